// File: rtl/aposta_tx.sv
// aposta_tx -- transmitter side of the lottery bet interface.
//
// Accepts one packed ticket over a valid/ready handshake and replays it into
// the Loteria checker as a fixed sequence:
//   novo_jogo pulse, NUM_DIGITS insere strobes (digit 0 first),
//   SETTLE_CYCLES of fim_jogo, one res_valid cycle with the captured result,
//   and a final fim pulse when the ticket was flagged as the session's last.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   aposta, aposta_valid,   packed ticket (digit i in bits [4i+3:4i]) offered by
//   ultimo, aposta_ready    the source; ultimo marks the last ticket of a session
//   numero, insere,         stimulus to Loteria
//   novo_jogo, fim_jogo, fim
//   premio, p1, p2          result from Loteria, sampled at the end of the settle window
//   res_valid, res_premio,  one-cycle result strobe; res_* hold until next capture
//   res_p1, res_p2
//   jogos                   completed-game count, saturating at 255
//   busy                    high whenever the sequencer is not idle
//
// Every output is a register loaded from the next-state decode, so nothing
// reaches an output combinationally from an input.

module aposta_tx #(
    parameter int NUM_DIGITS    = 5,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] aposta,
    input  logic                    aposta_valid,
    input  logic                    ultimo,
    output logic                    aposta_ready,
    output logic [3:0]              numero,
    output logic                    insere,
    output logic                    novo_jogo,
    output logic                    fim_jogo,
    output logic                    fim,
    input  logic [1:0]              premio,
    input  logic [4:0]              p1,
    input  logic [4:0]              p2,
    output logic                    res_valid,
    output logic [1:0]              res_premio,
    output logic [4:0]              res_p1,
    output logic [4:0]              res_p2,
    output logic [7:0]              jogos,
    output logic                    busy
);

    // One counter serves both the digit index (ENVIA) and the settle window (ESPERA).
    localparam int CNT_MAX = (NUM_DIGITS > SETTLE_CYCLES) ? NUM_DIGITS : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_NOVO    = 3'd1,
        S_ENVIA   = 3'd2,
        S_ESPERA  = 3'd3,
        S_CAPTURA = 3'd4,
        S_FINAL   = 3'd5
    } state_t;

    state_t                    r_state;
    state_t                    w_nxt_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_nxt_cnt;
    logic [4*NUM_DIGITS-1:0]   r_ticket;
    logic                      r_ultimo;

    logic                      w_xfer;
    logic                      w_capture;

    logic                      w_ready;
    logic [3:0]                w_numero;
    logic                      w_insere;
    logic                      w_novo;
    logic                      w_fim_jogo;
    logic                      w_fim;
    logic                      w_res_valid;
    logic                      w_busy;

    logic                      r_ready;
    logic [3:0]                r_numero;
    logic                      r_insere;
    logic                      r_novo;
    logic                      r_fim_jogo;
    logic                      r_fim;
    logic                      r_res_valid;
    logic [1:0]                r_res_premio;
    logic [4:0]                r_res_p1;
    logic [4:0]                r_res_p2;
    logic [7:0]                r_jogos;
    logic                      r_busy;

    // r_ready is exactly "state is IDLE" once out of reset, so it doubles as the
    // handshake qualifier.
    assign w_xfer    = aposta_valid & r_ready;
    // Result is sampled on the edge that closes the last settle cycle.
    assign w_capture = (r_state == S_ESPERA) && (w_nxt_state == S_CAPTURA);

    // State register, ticket register, output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_ticket     <= '0;
            r_ultimo     <= 1'b0;
            r_ready      <= 1'b0;
            r_numero     <= 4'd0;
            r_insere     <= 1'b0;
            r_novo       <= 1'b0;
            r_fim_jogo   <= 1'b0;
            r_fim        <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_premio <= 2'd0;
            r_res_p1     <= 5'd0;
            r_res_p2     <= 5'd0;
            r_jogos      <= 8'd0;
            r_busy       <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_ready     <= w_ready;
            r_numero    <= w_numero;
            r_insere    <= w_insere;
            r_novo      <= w_novo;
            r_fim_jogo  <= w_fim_jogo;
            r_fim       <= w_fim;
            r_res_valid <= w_res_valid;
            r_busy      <= w_busy;
            if (w_xfer) begin
                r_ticket <= aposta;
                r_ultimo <= ultimo;
            end
            if (w_capture) begin
                r_res_premio <= premio;
                r_res_p1     <= p1;
                r_res_p2     <= p2;
                if (r_jogos != 8'hFF) begin
                    r_jogos <= r_jogos + 8'd1;
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_nxt_state = S_NOVO;
                end
            end
            S_NOVO: begin
                w_nxt_state = S_ENVIA;
                w_nxt_cnt   = '0;
            end
            S_ENVIA: begin
                if (r_cnt == CNT_W'(NUM_DIGITS - 1)) begin
                    w_nxt_state = S_ESPERA;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            S_ESPERA: begin
                if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    w_nxt_state = S_CAPTURA;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            S_CAPTURA: begin
                w_nxt_state = r_ultimo ? S_FINAL : S_IDLE;
            end
            S_FINAL: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // Output decode of the state being entered; registered above so each
    // strobe lines up with the cycle its state occupies.
    always_comb begin
        w_ready     = (w_nxt_state == S_IDLE);
        w_busy      = (w_nxt_state != S_IDLE);
        w_novo      = (w_nxt_state == S_NOVO);
        w_insere    = (w_nxt_state == S_ENVIA);
        w_fim_jogo  = (w_nxt_state == S_ESPERA);
        w_res_valid = (w_nxt_state == S_CAPTURA);
        w_fim       = (w_nxt_state == S_FINAL);
        w_numero    = 4'd0;
        if (w_nxt_state == S_ENVIA) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_nxt_cnt == CNT_W'(i)) begin
                    w_numero = r_ticket[4*i +: 4];
                end
            end
        end
    end

    assign aposta_ready = r_ready;
    assign numero       = r_numero;
    assign insere       = r_insere;
    assign novo_jogo    = r_novo;
    assign fim_jogo     = r_fim_jogo;
    assign fim          = r_fim;
    assign res_valid    = r_res_valid;
    assign res_premio   = r_res_premio;
    assign res_p1       = r_res_p1;
    assign res_p2       = r_res_p2;
    assign jogos        = r_jogos;
    assign busy         = r_busy;

endmodule
